// File: rtl/input_conditioner.sv
// Debounces 4 buttons and 16 switches on a shared sample tick, makes
// button press strobes, and produces a synchronised active-high reset.
// Ports: clk, RSTN (async active-low) | Key_y[3:0], SW[15:0] raw levels
//        BTN_OK, BTN_PULSE, SW_OK debounced outputs | rst system reset.
module input_conditioner #(
  parameter int TICK_DIV = 100000,
  parameter int STABLE_N = 8
) (
  input  logic        clk,
  input  logic        RSTN,
  input  logic [3:0]  Key_y,
  input  logic [15:0] SW,
  output logic [3:0]  BTN_OK,
  output logic [3:0]  BTN_PULSE,
  output logic [15:0] SW_OK,
  output logic        rst
);

  localparam int N  = 20;
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] PLAST = CW'(TICK_DIV - 1);
  localparam logic [3:0]    QLAST = 4'(STABLE_N - 1);

  // reset: asserts at once, releases two edges after RSTN rises
  logic [1:0] rst_q;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) rst_q <= 2'b11;
    else       rst_q <= {rst_q[0], 1'b0};
  end

  assign rst = rst_q[1];

  logic [N-1:0] raw;
  logic [N-1:0] s1;
  logic [N-1:0] s2;

  assign raw = {SW, Key_y};

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  logic [CW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == PLAST);

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN)     pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + CW'(1);
  end

  logic [3:0]   cnt     [N];
  logic [3:0]   cnt_nxt [N];
  logic [N-1:0] ok;
  logic [N-1:0] ok_nxt;

  // any tick sample equal to ok restarts qualification
  always_comb begin
    ok_nxt = ok;
    for (int i = 0; i < N; i++) begin
      cnt_nxt[i] = cnt[i];
      if (tick) begin
        if (s2[i] != ok[i]) begin
          if (cnt[i] == QLAST) begin
            ok_nxt[i]  = s2[i];
            cnt_nxt[i] = '0;
          end else begin
            cnt_nxt[i] = cnt[i] + 4'd1;
          end
        end else begin
          cnt_nxt[i] = '0;
        end
      end
    end
  end

  logic [3:0] pulse;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      cnt   <= '{default: '0};
      ok    <= '0;
      pulse <= '0;
    end else begin
      cnt   <= cnt_nxt;
      ok    <= ok_nxt;
      // lines up with the cycle BTN_OK first reads 1
      pulse <= ok_nxt[3:0] & ~ok[3:0];
    end
  end

  assign BTN_OK    = ok[3:0];
  assign SW_OK     = ok[19:4];
  assign BTN_PULSE = pulse;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with TICK_DIV=4, STABLE_N=3.
// Expected output changes are queued at stimulus time, popped on change.
module tb_input_conditioner;

  localparam int TD = 4;
  localparam int SN = 3;

  logic        clk = 1'b0;
  logic        RSTN = 1'b1;
  logic [3:0]  Key_y = '0;
  logic [15:0] SW = '0;
  logic [3:0]  BTN_OK;
  logic [3:0]  BTN_PULSE;
  logic [15:0] SW_OK;
  logic        rst;

  always #5 clk = ~clk;

  input_conditioner #(
    .TICK_DIV(TD),
    .STABLE_N(SN)
  ) dut (
    .clk(clk),
    .RSTN(RSTN),
    .Key_y(Key_y),
    .SW(SW),
    .BTN_OK(BTN_OK),
    .BTN_PULSE(BTN_PULSE),
    .SW_OK(SW_OK),
    .rst(rst)
  );

  wire [23:0] outs = {BTN_OK, BTN_PULSE, SW_OK};

  typedef struct {
    string       tag;
    logic [23:0] exp;
    int          lo;
    int          hi;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_rng(input string tag, input int v,
                         input int lo, input int hi);
    n_chk++;
    assert (v >= lo && v <= hi) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d..%0d", tag, v, lo, hi);
  endtask

  task automatic push(input string tag, input logic [23:0] exp,
                      input int lo, input int hi);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    e.lo  = lo;
    e.hi  = hi;
    sb.push_back(e);
  endtask

  // waits for the next output change, then checks it against the queue
  task automatic expect_change();
    exp_t        e;
    logic [23:0] snap;
    int          lat;
    e    = sb.pop_front();
    snap = outs;
    lat  = 0;
    while (outs === snap && lat < e.hi + 5) begin
      @(negedge clk);
      lat++;
    end
    chk(e.tag, outs, e.exp);
    chk_rng({e.tag, "_latency"}, lat, e.lo, e.hi);
  endtask

  logic        saw;
  logic        pt;
  logic [19:0] pv;
  int          ticks;
  int          bad;
  int          n;

  initial begin
    #2;
    Key_y = 4'($urandom);
    SW    = 16'($urandom);
    RSTN  = 1'b0;
    #1;
    chk("rst_btn_ok", BTN_OK, 0);
    chk("rst_btn_pulse", BTN_PULSE, 0);
    chk("rst_sw_ok", SW_OK, 0);
    chk("rst_asserted", rst, 1);
    repeat (3) @(negedge clk);
    chk("rst_held_outs", outs, 0);
    Key_y = '0;
    SW    = '0;
    @(negedge clk);
    RSTN = 1'b1;
    @(posedge clk);
    #1 chk("rst_edge1", rst, 1);
    @(posedge clk);
    #1 chk("rst_edge2", rst, 0);
    repeat (10) @(negedge clk);

    // clean press and release
    Key_y[0] = 1'b1;
    push("press0", {4'h1, 4'h1, 16'h0}, 10, 15);
    expect_change();
    @(negedge clk);
    chk("press0_pulse_once", BTN_PULSE, 0);
    chk("press0_held", BTN_OK, 4'h1);
    repeat (5) @(negedge clk);
    Key_y[0] = 1'b0;
    push("release0", 24'h0, 10, 15);
    expect_change();

    // bouncing switch settling low
    saw = 1'b0;
    repeat (4) begin
      SW[3] = 1'b1;
      repeat (5) begin @(negedge clk); saw |= SW_OK[3]; end
      SW[3] = 1'b0;
      repeat (5) begin @(negedge clk); saw |= SW_OK[3]; end
    end
    repeat (20) begin @(negedge clk); saw |= SW_OK[3]; end
    chk("bounce_low_stays0", saw, 0);

    // bouncing switch settling high
    repeat (4) begin
      SW[3] = 1'b1;
      repeat (5) begin @(negedge clk); saw |= SW_OK[3]; end
      SW[3] = 1'b0;
      repeat (5) begin @(negedge clk); saw |= SW_OK[3]; end
    end
    chk("bounce_pre_high0", saw, 0);
    SW[3] = 1'b1;
    push("bounce_high", {4'h0, 4'h0, 16'h0008}, 10, 15);
    expect_change();
    SW[3] = 1'b0;
    push("bounce_release", 24'h0, 10, 15);
    expect_change();

    // simultaneous qualification
    Key_y = 4'hF;
    SW    = 16'hA5C3;
    push("simul", {4'hF, 4'hF, 16'hA5C3}, 10, 15);
    expect_change();
    @(negedge clk);
    chk("simul_pulse_once", BTN_PULSE, 0);
    chk("simul_hold", {BTN_OK, SW_OK}, {4'hF, 16'hA5C3});
    Key_y = '0;
    SW    = '0;
    push("simul_release", 24'h0, 10, 15);
    expect_change();

    // reset in the middle of qualification
    repeat (3) @(negedge clk);
    Key_y[2] = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_pre", BTN_OK, 0);
    RSTN = 1'b0;
    #1;
    chk("midrst_ok_cleared", BTN_OK, 0);
    chk("midrst_rst", rst, 1);
    @(negedge clk);
    RSTN = 1'b1;
    n = 0;
    while (rst !== 1'b0 && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_release_edges", n, 2);
    push("midrst_press2", {4'h4, 4'h4, 16'h0}, 10, 20);
    expect_change();
    @(negedge clk);
    chk("midrst_pulse_once", BTN_PULSE, 0);
    Key_y[2] = 1'b0;
    push("midrst_release2", 24'h0, 10, 15);
    expect_change();

    // prescaler period and tick-aligned updates
    ticks = 0;
    bad   = 0;
    pt    = dut.tick;
    pv    = {BTN_OK, SW_OK};
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        Key_y = 4'($urandom);
        SW    = 16'($urandom);
      end
      @(negedge clk);
      if (pt) ticks++;
      if ({BTN_OK, SW_OK} !== pv && !pt) bad++;
      pt = dut.tick;
      pv = {BTN_OK, SW_OK};
    end
    chk("tick_count", ticks, 100);
    chk("ok_only_on_tick", bad, 0);
    Key_y = '0;
    SW    = '0;
    repeat (30) @(negedge clk);
    chk("final_idle", outs, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter TICK_DIV, default 100000, clk cycles per debounce sample tick (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 Parameter STABLE_N, default 8, consecutive mismatching ticks needed to accept a new level; legal range 2..15.
REQ-003 clk  input  1  board clock (100 MHz); all state updates on its rising edge.
REQ-004 RSTN  input  1  reset; asynchronous, active-low.
REQ-005 Key_y  input  4  raw push-button levels; asynchronous to clk.
REQ-006 SW  input  16  raw slide-switch levels; asynchronous to clk.
REQ-007 BTN_OK  output  4  debounced button levels, registered.
REQ-008 BTN_PULSE  output  4  one-cycle press strobe per button, registered.
REQ-009 SW_OK  output  16  debounced switch levels, registered.
REQ-010 rst  output  1  active-high system reset; asserts asynchronously and releases synchronously.

Function
REQ-011 Each of the 20 raw inputs SHALL pass through a 2-flop synchronizer before any other use; sync value = second flop.
REQ-012 One shared prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; tick is high for exactly the cycle in which the count equals TICK_DIV-1.
REQ-013 Each input SHALL have its own 4-bit stable counter cnt and accepted level ok (ok drives BTN_OK / SW_OK).
REQ-014 On a tick cycle with sync != ok and cnt == STABLE_N-1: ok <= sync and cnt <= 0.
REQ-015 On a tick cycle with sync != ok and cnt < STABLE_N-1: cnt <= cnt+1.
REQ-016 On a tick cycle with sync == ok: cnt <= 0.
REQ-017 On non-tick cycles, cnt and ok SHALL hold.
REQ-018 Any single tick sample equal to ok SHALL restart qualification, so a glitch shorter than STABLE_N consecutive ticks never changes ok.
REQ-019 Acceptance latency from a clean raw edge to the ok change SHALL be between 2+(STABLE_N-1)*TICK_DIV and 3+STABLE_N*TICK_DIV cycles inclusive.
REQ-020 BTN_PULSE[i] SHALL be high exactly during the first cycle in which BTN_OK[i] is 1 after having been 0.
REQ-021 BTN_PULSE SHALL never assert on a button release or while BTN_OK is held high.
REQ-022 Inputs SHALL be independent; inputs that qualify on the same tick SHALL update ok in the same cycle, with simultaneous pulses where applicable.
REQ-023 rst SHALL be 1 whenever RSTN is 0, and SHALL fall on the 2nd rising clk edge after RSTN deasserts, via a 2-flop synchronizer preset to 1.
REQ-024 Operation during rst == 1 with RSTN == 1 (the release window) SHALL be normal; debouncing proceeds.

Reset
REQ-025 RSTN low SHALL asynchronously clear the synchronizers, prescaler, all cnt, BTN_OK, SW_OK and BTN_PULSE to 0, and set rst to 1.
REQ-026 A reset arriving mid-qualification SHALL discard partial counts, so a full STABLE_N-tick qualification is required after release.
REQ-027 Inputs already at 1 when reset releases SHALL be accepted through the normal debounce path; BTN_PULSE fires for buttons.

Verification (bench uses TICK_DIV=4, STABLE_N=3)
REQ-028 Reset: RSTN=0 with random inputs -> all outputs 0 and rst=1 immediately; RSTN 0->1 -> rst=1 through the 1st edge, 0 after the 2nd edge.
REQ-029 Clean press: Key_y[0] 0->1 held -> BTN_OK[0] rises 10..15 cycles later, with BTN_PULSE[0]=1 for exactly that one cycle; release -> BTN_OK[0] falls 10..15 cycles later, with no pulse.
REQ-030 Bounce: SW[3] driven high 5 cycles / low 5 cycles, 4 repetitions, then low -> SW_OK[3] stays 0 throughout; the same pattern ending in a steady high -> SW_OK[3] becomes 1 within 15 cycles of the final rise.
REQ-031 Simultaneous: Key_y=4'hF and SW=16'hA5C3 in one cycle -> BTN_OK=4'hF and SW_OK=16'hA5C3 update in the same cycle, with BTN_PULSE=4'hF for one cycle.
REQ-032 Mid-operation reset: press Key_y[2], pulse RSTN low for 1 cycle after 2 ticks while holding Key_y[2]=1 -> BTN_OK[2]=0; BTN_OK[2] rises no earlier than 10 cycles after rst falls, and BTN_PULSE[2] fires once.
REQ-033 Prescaler wrap: over 400 cycles, tick count = 100 exactly, and no ok change occurs except on tick cycles.
